otp_access_sequencer: RTL and testbench
=======================================

Name: otp_access_sequencer

Overview:
Sequences all accesses to the OTP macro. Runs an automatic trim boot load after reset, then serves I2C host-interface (HIF) read and program requests one at a time. Drives OTP address, chip-enable, read and program strobes with fixed setup, pulse and hold timing, and captures i_otp_q. Sits in digtop between the HIF register block, the OTP macro and the trim register bank.

Parameters:
ADDR_W, 6, OTP word address width
DATA_W, 8, OTP word width
RD_PULSE, 4, otp_rd high time in xtal_clk cycles (>=1)
PGM_PULSE, 100, otp_pgm high time in xtal_clk cycles (>=1)
BOOT_WORDS, 8, words loaded at boot from addresses 0..BOOT_WORDS-1 (1..2**ADDR_W)

Ports:
xtal_clk  in  1  sole clock, all state on rising edge
por_rst  in  1  synchronous active-high reset
scan_en  in  1  1 = do not start new OTP operations
pgm_en  in  1  program-enable guard from lock logic
hif_req  in  1  host request, level, held until hif_ack
hif_we  in  1  1 = program, 0 = read
hif_addr  in  ADDR_W  host word address
hif_wdata  in  DATA_W  program data
hif_ack  out  1  one-cycle completion pulse
hif_err  out  1  valid with hif_ack; 1 = program refused
hif_rdata  out  DATA_W  read data, valid from hif_ack, held until next read completes
hif_busy  out  1  1 while boot active or FSM not IDLE
boot_done  out  1  sticky 1 after last boot word written
trim_we  out  1  one-cycle trim write strobe
trim_addr  out  ADDR_W  trim index
trim_data  out  DATA_W  trim word
otp_ce  out  1  OTP chip enable
otp_rd  out  1  read strobe
otp_pgm  out  1  program strobe
otp_addr  out  ADDR_W  OTP address
otp_d  out  DATA_W  program data to macro
i_otp_q  in  DATA_W  OTP read data

Behaviour:
- Reset (por_rst=1 at an edge): state IDLE, boot pointer 0, all outputs 0 incl. boot_done, hif_rdata; strobes low at that edge. Reset mid-pulse aborts immediately, no ack; boot restarts after release.
- All outputs registered. FSM states: IDLE, SETUP, STROBE, CAPTURE, HOLD.
- IDLE: if !scan_en and !boot_done, start boot read at boot pointer. Else if !scan_en and boot_done and hif_req: latch hif_addr/hif_we/hif_wdata, go SETUP. Boot has absolute priority; hif_req is ignored until boot_done.
- Program with pgm_en=0 when latched: no SETUP; next cycle hif_ack=1, hif_err=1, return IDLE; no OTP pins toggle.
- SETUP (1 cycle): otp_ce=1, otp_addr valid, otp_d=wdata if program.
- STROBE: otp_rd (read) or otp_pgm (program) high exactly RD_PULSE or PGM_PULSE cycles; down-counter loaded on entry. ce, addr and d stable throughout.
- CAPTURE (1 cycle): strobes low, ce=1; on read, i_otp_q registered at end of cycle.
- HOLD (1 cycle): ce=1, addr held. Host op: hif_ack=1, hif_err=0; hif_rdata updated for reads only. Boot op: trim_we=1, trim_addr=pointer, trim_data=captured word; pointer++; after word BOOT_WORDS-1, boot_done=1 from the next cycle. Then IDLE with ce=0.
- Read latency: request accepted at edge t -> hif_ack high in cycle t+3+RD_PULSE (t+7 at default). Program latency: t+3+PGM_PULSE.
- hif_req must drop the cycle after hif_ack. A request still high in the IDLE cycle after HOLD starts a new op. Back-to-back ops have at least 1 IDLE cycle with ce=0.
- scan_en is sampled only in IDLE. An op already in progress completes normally.
- hif_busy = !boot_done | (state != IDLE).
- Boot pointer never wraps; boot runs once per reset.

Decomposition:
- Package otp_seq_pkg: state enum (IDLE, SETUP, STROBE, CAPTURE, HOLD), SETUP_CYC=1, HOLD_CYC=1, op-type encoding.
- Sub-module otp_pulse_timer: loadable down-counter sized to max(RD_PULSE, PGM_PULSE), with load/done outputs for STROBE width.

Test Plan:
- Reset release with OTP model words 0..7 = 8'hA0..8'hA7 -> exactly 8 trim_we pulses, trim_addr 0..7, data A0..A7; boot_done high after the 8th; each otp_rd pulse exactly 4 cycles.
- After boot, read addr 6'h15 holding 8'h3C -> hif_ack exactly 7 cycles after acceptance, hif_rdata=8'h3C, hif_err=0.
- Program addr 6'h02 data 8'h5A, pgm_en=1 -> otp_pgm high exactly 100 cycles, otp_d=8'h5A stable SETUP..HOLD, hif_ack at acceptance+103.
- Program with pgm_en=0 -> hif_ack with hif_err=1 one cycle after acceptance; otp_ce/otp_pgm never asserted.
- hif_req asserted during boot -> served only after boot_done; scan_en=1 in IDLE blocks start, scan_en=1 mid-STROBE does not shorten the pulse.
- por_rst pulse mid-boot at word 3 -> strobes low next edge, no trim_we for word 3, boot restarts at address 0.

Source files
------------

// File: rtl/otp_seq_pkg.sv
// Shared types for the OTP access sequencer: FSM states, operation kinds and
// fixed phase lengths around the read/program strobe.
package otp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_CAPTURE,
        ST_HOLD
    } state_e;

    typedef enum logic [1:0] {
        OP_BOOT_RD,
        OP_HOST_RD,
        OP_HOST_PGM
    } op_e;

    localparam int SETUP_CYC = 1;
    localparam int HOLD_CYC  = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/otp_pulse_timer.sv
// Loadable down-counter that times the STROBE phase; o_done marks its last cycle.
module otp_pulse_timer #(
    parameter int CNT_W = 7
) (
    input  logic             xtal_clk,
    input  logic             por_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge xtal_clk) begin
        if (por_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_len;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/otp_access_sequencer.sv
// Sole owner of the OTP macro pins: boot-loads trim words after reset, then
// serves host read/program requests with fixed setup/strobe/capture/hold timing.
module otp_access_sequencer
    import otp_seq_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 8,
    parameter int RD_PULSE   = 4,
    parameter int PGM_PULSE  = 100,
    parameter int BOOT_WORDS = 8
) (
    input  logic              xtal_clk,
    input  logic              por_rst,
    input  logic              scan_en,
    input  logic              pgm_en,
    input  logic              hif_req,
    input  logic              hif_we,
    input  logic [ADDR_W-1:0] hif_addr,
    input  logic [DATA_W-1:0] hif_wdata,
    output logic              hif_ack,
    output logic              hif_err,
    output logic [DATA_W-1:0] hif_rdata,
    output logic              hif_busy,
    output logic              boot_done,
    output logic              trim_we,
    output logic [ADDR_W-1:0] trim_addr,
    output logic [DATA_W-1:0] trim_data,
    output logic              otp_ce,
    output logic              otp_rd,
    output logic              otp_pgm,
    output logic [ADDR_W-1:0] otp_addr,
    output logic [DATA_W-1:0] otp_d,
    input  logic [DATA_W-1:0] i_otp_q
);

    localparam int CNT_W = $clog2(max_int(RD_PULSE, PGM_PULSE) + 1);

    state_e            r_state, w_state_nxt;
    op_e               r_op, w_op_nxt;
    logic              r_refuse, w_refuse_nxt, w_latch;
    logic              w_timer_load, w_timer_done;
    logic [CNT_W-1:0]  w_timer_len;
    logic [ADDR_W-1:0] r_boot_ptr;
    logic              w_boot_last;
    logic              r_boot_done, w_boot_done_nxt;
    logic              w_ce_nxt, w_rd_nxt, w_pgm_nxt, w_ack_nxt, w_err_nxt;
    logic              w_trim_we_nxt, w_busy_nxt;
    logic              r_ack, r_err, r_busy, r_trim_we, r_ce, r_rd, r_pgm;
    logic [DATA_W-1:0] r_rdata, r_trim_data, r_otp_d;
    logic [ADDR_W-1:0] r_trim_addr, r_otp_addr;

    assign w_boot_last  = (r_boot_ptr == ADDR_W'(BOOT_WORDS - 1));
    assign w_timer_load = (r_state == ST_SETUP);
    assign w_timer_len  = (r_op == OP_HOST_PGM) ? CNT_W'(PGM_PULSE) : CNT_W'(RD_PULSE);

    otp_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .xtal_clk (xtal_clk),
        .por_rst  (por_rst),
        .i_load   (w_timer_load),
        .i_len    (w_timer_len),
        .o_done   (w_timer_done)
    );

    always_ff @(posedge xtal_clk) begin
        if (por_rst) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_BOOT_RD;
            r_refuse <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_op     <= w_op_nxt;
            r_refuse <= w_refuse_nxt;
        end
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_refuse_nxt = r_refuse;
        w_latch      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!scan_en && !r_boot_done) begin
                    w_state_nxt = ST_SETUP;
                    w_op_nxt    = OP_BOOT_RD;
                    w_latch     = 1'b1;
                end else if (!scan_en && hif_req) begin
                    w_op_nxt = hif_we ? OP_HOST_PGM : OP_HOST_RD;
                    if (hif_we && !pgm_en) begin
                        // Refused program skips the macro and acks from HOLD with ce low.
                        w_state_nxt  = ST_HOLD;
                        w_refuse_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_latch     = 1'b1;
                    end
                end
            end
            ST_SETUP:   w_state_nxt = ST_STROBE;
            ST_STROBE:  if (w_timer_done) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                w_state_nxt  = ST_IDLE;
                w_refuse_nxt = 1'b0;
            end
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up with it.
    always_comb begin
        w_ce_nxt        = (w_state_nxt inside {ST_SETUP, ST_STROBE, ST_CAPTURE}) ||
                          (w_state_nxt == ST_HOLD && !w_refuse_nxt);
        w_rd_nxt        = (w_state_nxt == ST_STROBE) && (w_op_nxt != OP_HOST_PGM);
        w_pgm_nxt       = (w_state_nxt == ST_STROBE) && (w_op_nxt == OP_HOST_PGM);
        w_ack_nxt       = (w_state_nxt == ST_HOLD) && (w_op_nxt != OP_BOOT_RD);
        w_err_nxt       = (w_state_nxt == ST_HOLD) && w_refuse_nxt;
        w_trim_we_nxt   = (w_state_nxt == ST_HOLD) && (w_op_nxt == OP_BOOT_RD);
        w_boot_done_nxt = r_boot_done ||
                          (r_state == ST_HOLD && r_op == OP_BOOT_RD && w_boot_last);
        w_busy_nxt      = !w_boot_done_nxt || (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge xtal_clk) begin
        if (por_rst) begin
            r_ce        <= 1'b0;
            r_rd        <= 1'b0;
            r_pgm       <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_trim_we   <= 1'b0;
            r_boot_done <= 1'b0;
            r_busy      <= 1'b0;
            r_otp_addr  <= '0;
            r_otp_d     <= '0;
            r_rdata     <= '0;
            r_trim_data <= '0;
            r_trim_addr <= '0;
            r_boot_ptr  <= '0;
        end else begin
            r_ce        <= w_ce_nxt;
            r_rd        <= w_rd_nxt;
            r_pgm       <= w_pgm_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_trim_we   <= w_trim_we_nxt;
            r_boot_done <= w_boot_done_nxt;
            r_busy      <= w_busy_nxt;
            if (w_latch) begin
                r_otp_addr <= (w_op_nxt == OP_BOOT_RD) ? r_boot_ptr : hif_addr;
                r_otp_d    <= (w_op_nxt == OP_HOST_PGM) ? hif_wdata : '0;
            end
            if (r_state == ST_CAPTURE) begin
                if (r_op == OP_HOST_RD) r_rdata <= i_otp_q;
                if (r_op == OP_BOOT_RD) begin
                    r_trim_data <= i_otp_q;
                    r_trim_addr <= r_boot_ptr;
                end
            end
            if (r_state == ST_HOLD && r_op == OP_BOOT_RD && !w_boot_last) begin
                r_boot_ptr <= r_boot_ptr + 1'b1;
            end
        end
    end

    assign otp_ce    = r_ce;
    assign otp_rd    = r_rd;
    assign otp_pgm   = r_pgm;
    assign otp_addr  = r_otp_addr;
    assign otp_d     = r_otp_d;
    assign hif_ack   = r_ack;
    assign hif_err   = r_err;
    assign hif_rdata = r_rdata;
    assign hif_busy  = r_busy;
    assign boot_done = r_boot_done;
    assign trim_we   = r_trim_we;
    assign trim_addr = r_trim_addr;
    assign trim_data = r_trim_data;

endmodule

// File: tb/tb_otp_access_sequencer.sv
// Scoreboarded bench: a behavioural OTP macro plus a reference memory predict
// trim loads and host responses; monitors compare on trim_we/hif_ack and pin pulses.
`timescale 1ns/1ps
module tb_otp_access_sequencer;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int RD_PULSE   = 4;
    localparam int PGM_PULSE  = 100;
    localparam int BOOT_WORDS = 8;
    localparam int WORD_CYC   = RD_PULSE + 4;

    typedef struct {
        int              cyc;
        logic            err;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    typedef struct {
        int              cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } trim_t;

    logic              xtal_clk = 1'b0;
    logic              por_rst, scan_en, pgm_en, hif_req, hif_we;
    logic [ADDR_W-1:0] hif_addr;
    logic [DATA_W-1:0] hif_wdata;
    logic              hif_ack, hif_err, hif_busy, boot_done, trim_we;
    logic [DATA_W-1:0] hif_rdata, trim_data, otp_d, i_otp_q;
    logic [ADDR_W-1:0] trim_addr, otp_addr;
    logic              otp_ce, otp_rd, otp_pgm;

    logic [DATA_W-1:0] mem_otp [2**ADDR_W];
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    logic [DATA_W-1:0] last_rd = '0;

    exp_t  sb_q[$];
    trim_t trim_q[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    n_ce_rise = 0;
    int    n_pgm_rise = 0;

    otp_access_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_PULSE(RD_PULSE),
        .PGM_PULSE(PGM_PULSE), .BOOT_WORDS(BOOT_WORDS)
    ) dut (
        .xtal_clk(xtal_clk), .por_rst(por_rst), .scan_en(scan_en), .pgm_en(pgm_en),
        .hif_req(hif_req), .hif_we(hif_we), .hif_addr(hif_addr), .hif_wdata(hif_wdata),
        .hif_ack(hif_ack), .hif_err(hif_err), .hif_rdata(hif_rdata), .hif_busy(hif_busy),
        .boot_done(boot_done), .trim_we(trim_we), .trim_addr(trim_addr),
        .trim_data(trim_data), .otp_ce(otp_ce), .otp_rd(otp_rd), .otp_pgm(otp_pgm),
        .otp_addr(otp_addr), .otp_d(otp_d), .i_otp_q(i_otp_q)
    );

    always #5 xtal_clk = ~xtal_clk;
    always @(posedge xtal_clk) cyc <= cyc + 1;

    // Macro model: reads are combinational from the address, programming lands during the pulse.
    assign i_otp_q = mem_otp[otp_addr];
    always @(negedge xtal_clk) if (otp_pgm) mem_otp[otp_addr] <= otp_d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge xtal_clk) begin
        if (hif_ack) begin
            check("ack_pending", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("ack_cycle", cyc, e.cyc);
                check("ack_err", hif_err, e.err);
                check("ack_rdata", hif_rdata, e.rdata);
            end
        end
        if (trim_we) begin
            check("trim_pending", trim_q.size() != 0, 1);
            if (trim_q.size() != 0) begin
                trim_t t;
                t = trim_q.pop_front();
                check("trim_cycle", cyc, t.cyc);
                check("trim_addr", trim_addr, t.addr);
                check("trim_data", trim_data, t.data);
            end
        end
    end

    int                rd_len = 0, pgm_len = 0;
    logic              ce_prev = 1'b0, ce_bad = 1'b0;
    logic [ADDR_W-1:0] ce_addr;
    logic [DATA_W-1:0] ce_d;

    always @(negedge xtal_clk) begin
        if (por_rst) begin
            rd_len = 0; pgm_len = 0; ce_prev = 1'b0; ce_bad = 1'b0;
        end else begin
            if (otp_rd) rd_len++;
            else if (rd_len != 0) begin
                check("rd_pulse_len", rd_len, RD_PULSE);
                rd_len = 0;
            end
            if (otp_pgm) begin
                if (pgm_len == 0) n_pgm_rise++;
                pgm_len++;
            end else if (pgm_len != 0) begin
                check("pgm_pulse_len", pgm_len, PGM_PULSE);
                pgm_len = 0;
            end
            if (otp_ce) begin
                if (!ce_prev) begin
                    n_ce_rise++;
                    ce_addr = otp_addr;
                    ce_d    = otp_d;
                    ce_bad  = 1'b0;
                end else if (otp_addr != ce_addr || otp_d != ce_d) begin
                    ce_bad = 1'b1;
                end
            end else if (ce_prev) begin
                check("ce_pins_stable", ce_bad, 0);
            end
            ce_prev = otp_ce;
        end
    end

    task automatic push_boot(input int r, input int n_words);
        for (int k = 0; k < n_words; k++) begin
            trim_t t;
            t.cyc  = r + k * WORD_CYC + RD_PULSE + 3;
            t.addr = ADDR_W'(k);
            t.data = ref_mem[k];
            trim_q.push_back(t);
        end
    endtask

    // acc is the IDLE cycle in which the request is expected to be accepted.
    task automatic issue_op(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd, input logic pen, input int acc);
        exp_t e;
        hif_we = we; hif_addr = addr; hif_wdata = wd; pgm_en = pen; hif_req = 1'b1;
        e.err = we && !pen;
        e.cyc = e.err ? acc + 1 : acc + 3 + (we ? PGM_PULSE : RD_PULSE);
        if (!we) last_rd = ref_mem[addr];
        else if (pen) ref_mem[addr] = wd;
        e.rdata = last_rd;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge xtal_clk);
            n++;
        end while (!hif_ack && n < 400);
        if (!hif_ack) check("ack_timeout", hif_ack, 1);
        hif_req = 1'b0;
    endtask

    task automatic do_op(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd, input logic pen, input int gap);
        issue_op(we, addr, wd, pen, cyc);
        wait_ack();
        repeat (1 + gap) @(negedge xtal_clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r, n, ce0, pgm0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            logic [DATA_W-1:0] v;
            v = (i < BOOT_WORDS) ? DATA_W'(8'hA0 + i) : DATA_W'($urandom);
            if (i == 6'h15) v = 8'h3C;
            mem_otp[i] = v;
            ref_mem[i] = v;
        end
        por_rst = 1'b1; scan_en = 1'b0; pgm_en = 1'b0; hif_req = 1'b0;
        hif_we = 1'b0; hif_addr = '0; hif_wdata = '0;
        repeat (3) @(negedge xtal_clk);
        check("reset_outputs",
              {hif_ack, hif_err, hif_rdata, hif_busy, boot_done, trim_we, trim_addr,
               trim_data, otp_ce, otp_rd, otp_pgm, otp_addr, otp_d}, 0);

        // First boot is cut by reset during word 3's strobe.
        r = cyc; por_rst = 1'b0;
        push_boot(r, 3);
        repeat (3 * WORD_CYC + 2) @(negedge xtal_clk);
        check("abort_rd_active", otp_rd, 1);
        por_rst = 1'b1;
        @(negedge xtal_clk);
        check("abort_strobes_low", {otp_rd, otp_pgm, otp_ce, trim_we, boot_done}, 0);
        @(negedge xtal_clk);

        // Clean boot with a host read pending from the start.
        r = cyc; por_rst = 1'b0;
        push_boot(r, BOOT_WORDS);
        repeat (5) @(negedge xtal_clk);
        issue_op(1'b0, 6'h15, '0, 1'b1, r + BOOT_WORDS * WORD_CYC);
        n = 0;
        while (!boot_done && n < 1000) begin
            @(negedge xtal_clk);
            n++;
        end
        check("boot_done_cycle", cyc, r + BOOT_WORDS * WORD_CYC);
        wait_ack();
        @(negedge xtal_clk);

        do_op(1'b0, 6'h15, '0, 1'b1, 2);
        do_op(1'b1, 6'h02, 8'h5A, 1'b1, 0);
        do_op(1'b0, 6'h02, '0, 1'b1, 1);

        ce0 = n_ce_rise; pgm0 = n_pgm_rise;
        do_op(1'b1, 6'h09, 8'hC3, 1'b0, 1);
        check("refuse_no_ce", n_ce_rise - ce0, 0);
        check("refuse_no_pgm", n_pgm_rise - pgm0, 0);
        do_op(1'b0, 6'h09, '0, 1'b1, 0);

        // scan_en held in IDLE blocks the start.
        scan_en = 1'b1; hif_we = 1'b0; hif_addr = 6'h03; hif_req = 1'b1;
        repeat (6) begin
            @(negedge xtal_clk);
            check("scan_block_busy", hif_busy, 0);
            check("scan_block_ce", otp_ce, 0);
        end
        scan_en = 1'b0;
        issue_op(1'b0, 6'h03, '0, 1'b1, cyc);
        wait_ack();
        @(negedge xtal_clk);

        // scan_en raised mid-strobe must not shorten the pulse.
        issue_op(1'b0, 6'h15, '0, 1'b1, cyc);
        repeat (3) @(negedge xtal_clk);
        scan_en = 1'b1;
        wait_ack();
        scan_en = 1'b0;
        @(negedge xtal_clk);

        for (int i = 0; i < 40; i++) begin
            do_op($urandom_range(0, 3) == 0, ADDR_W'($urandom), DATA_W'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3));
        end

        repeat (10) @(negedge xtal_clk);
        check("sb_drained", sb_q.size(), 0);
        check("trim_drained", trim_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
